// File: rtl/neg_abs_seq_unit_if.sv
// Handshake/data bundle for neg_abs_seq_unit.
// master: control unit side (drives request); slave: the unit itself.
interface neg_abs_seq_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             ovf;

  modport master (
    output start, mode, operand,
    input  result, done, busy, ovf
  );

  modport slave (
    input  start, mode, operand,
    output result, done, busy, ovf
  );
endinterface

// File: rtl/neg_abs_seq_unit.sv
// neg_abs_seq_unit: multi-cycle two's-complement PASS/NEG/ABS unit.
// Processes CHUNK bits per cycle with the +1 carry rippling across cycles;
// done pulses NCHUNK cycles after the accepting edge.
// Optional build macro NEG_ABS_SAT_EN: saturate the most-negative overflow
// case to the most positive value instead of wrapping.
module neg_abs_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic               clk,
  input logic               clr,
  neg_abs_seq_unit_if.slave bus
);

  localparam int unsigned      NCHUNK   = WIDTH / CHUNK;
  localparam int unsigned      IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  state_t           state_q;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, carry_d;
  logic             inv_q;
  logic             ovf_pend_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q, busy_q, ovf_q;

  logic [CHUNK-1:0] slice;
  logic [CHUNK:0]   sum;
  logic             accept_inv;
  logic             last_chunk;

  // Select the active slice, add the rippling carry and write it back into the working operand.
  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) slice = opnd_q[k*CHUNK +: CHUNK];
    end
    sum     = {1'b0, slice ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry_q};
    carry_d = sum[CHUNK];
    opnd_d  = opnd_q;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) opnd_d[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end
    last_chunk = (idx_q == IDXW'(NCHUNK - 1));
  end

  // Decide whether the accepted operand gets inverted (+1 comes from the initial carry).
  always_comb begin
    accept_inv = 1'b0;
    case (mode_t'(bus.mode))
      MODE_NEG: accept_inv = 1'b1;
      MODE_ABS: accept_inv = bus.operand[WIDTH-1];
      default:  accept_inv = 1'b0;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      opnd_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      inv_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_BUSY;
            opnd_q     <= bus.operand;
            inv_q      <= accept_inv;
            carry_q    <= accept_inv;
            ovf_pend_q <= accept_inv && (bus.operand == MOST_NEG);
            idx_q      <= '0;
            busy_q     <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          opnd_q  <= opnd_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            state_q <= S_DONE;
            idx_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= ovf_pend_q;
`ifdef NEG_ABS_SAT_EN
            result_q <= ovf_pend_q ? MOST_POS : opnd_d;
`else
            // Wrapped negation of the most-negative value already equals the operand.
            result_q <= opnd_d;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifndef NEG_ABS_SAT_EN
  logic unused_most_pos;
  assign unused_most_pos = ^MOST_POS;
`endif

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.ovf    = ovf_q;

endmodule
